// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit single-cycle CPU: sequencer states, run modes
// and instruction width.
package cpu_pkg;

  localparam int INSTR_W = 8;

  // 2'd3 is unused; the sequencer treats it as illegal and recovers to ST_HALT.
  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } seqState_t;

  typedef enum logic {
    RUN  = 1'b0,
    STEP = 1'b1
  } runMode_t;

endpackage

// File: rtl/seq_watchdog.sv
// Fetch watchdog: counts consecutive enabled cycles and flags the TIMEOUT-th one.
module seq_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  // count holds the number of cycles already spent, so LAST marks the final allowed one.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/exec_sequencer.sv
// Run-control and fetch sequencer: fetches over req/ack, issues a one-cycle commit,
// and provides run/step/halt, PC breakpoint, fetch watchdog and retired counter.
module exec_sequencer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               run,
  input  logic               step,
  input  logic               halt,
  input  logic               bp_en,
  input  logic [7:0]         bp_addr,
  input  logic [7:0]         pc,
  output logic               imem_req,
  output logic [7:0]         imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               commit,
  output logic               halted,
  output logic               fault,
  output logic [CNT_W-1:0]   retired,
  output logic [1:0]         state
);

  seqState_t           stateQ;
  runMode_t            modeQ;
  logic                bpSkip;
  logic                haltPend;
  logic                fetchFirst;
  logic [INSTR_W-1:0]  instrQ;
  logic                commitQ;
  logic                haltedQ;
  logic                faultQ;
  logic [CNT_W-1:0]    retiredQ;
  logic                wdExpired;
  logic                bpHit;

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .Reset   (Reset),
    .clear   (stateQ != ST_FETCH),
    .enable  (stateQ == ST_FETCH),
    .expired (wdExpired)
  );

  // The breakpoint is judged only in the first FETCH cycle, against the PC that
  // was written at the end of the previous EXEC, so a hit never raises a request.
  assign bpHit = (stateQ == ST_FETCH) && fetchFirst && bp_en &&
                 (pc == bp_addr) && !bpSkip;

  assign imem_req  = (stateQ == ST_FETCH) && !bpHit;
  assign imem_addr = pc;

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values; the pulse outputs default low and are raised per transition.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      stateQ     <= ST_HALT;
      modeQ      <= STEP;
      bpSkip     <= 1'b0;
      haltPend   <= 1'b0;
      fetchFirst <= 1'b0;
      instrQ     <= '0;
      commitQ    <= 1'b0;
      haltedQ    <= 1'b1;
      faultQ     <= 1'b0;
      retiredQ   <= '0;
    end else begin
      commitQ    <= 1'b0;
      haltedQ    <= 1'b0;
      fetchFirst <= 1'b0;
      case (stateQ)
        ST_HALT: begin
          if (!halt && (run || step)) begin
            modeQ      <= run ? RUN : STEP;
            bpSkip     <= 1'b1;
            faultQ     <= 1'b0;
            fetchFirst <= 1'b1;
            stateQ     <= ST_FETCH;
          end else begin
            haltedQ <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (bpHit) begin
            haltPend <= 1'b0;
            haltedQ  <= 1'b1;
            stateQ   <= ST_HALT;
          end else if (imem_ack) begin
            instrQ  <= imem_data;
            bpSkip  <= 1'b0;
            commitQ <= 1'b1;
            stateQ  <= ST_EXEC;
            if (halt) haltPend <= 1'b1;
          end else if (wdExpired) begin
            faultQ   <= 1'b1;
            haltPend <= 1'b0;
            haltedQ  <= 1'b1;
            stateQ   <= ST_HALT;
          end else if (halt) begin
            haltPend <= 1'b1;
          end
        end
        ST_EXEC: begin
          retiredQ <= retiredQ + CNT_W'(1);
          if ((modeQ == RUN) && !haltPend && !halt) begin
            fetchFirst <= 1'b1;
            stateQ     <= ST_FETCH;
          end else begin
            haltPend <= 1'b0;
            haltedQ  <= 1'b1;
            stateQ   <= ST_HALT;
          end
        end
        default: begin
          haltPend <= 1'b0;
          haltedQ  <= 1'b1;
          stateQ   <= ST_HALT;
        end
      endcase
    end
  end

  assign instr   = instrQ;
  assign commit  = commitQ;
  assign halted  = haltedQ;
  assign fault   = faultQ;
  assign retired = retiredQ;
  assign state   = stateQ;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer; the bench plays the PC register and a
// programmable-latency instruction memory whose word at address a is a ^ 8'hA5.
module tb_exec_sequencer;

  logic       clk;
  logic       Reset;
  logic       run, step, halt;
  logic       bp_en;
  logic [7:0] bp_addr;
  logic [7:0] pc;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [7:0] instr;
  logic       commit;
  logic       halted;
  logic       fault;
  logic [3:0] retired;
  logic [1:0] state;

  int passCnt  = 0;
  int totalCnt = 0;

  int         ackDelay;
  int         reqCycles;
  int         addrErr, reqLenErr, instrErr, commitsSeen;
  logic [7:0] lastFetch;

  exec_sequencer #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .run       (run),
    .step      (step),
    .halt      (halt),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .pc        (pc),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .instr     (instr),
    .commit    (commit),
    .halted    (halted),
    .fault     (fault),
    .retired   (retired),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; the bench-side PC register increments when commit was high.
  task automatic tick();
    logic c;
    c = commit;
    @(posedge clk);
    #1;
    if (c === 1'b1) pc = pc + 8'd1;
    #1;
  endtask

  // One cycle of the memory model plus bookkeeping, then advance the clock.
  task automatic cycle();
    if (imem_req === 1'b1) begin
      reqCycles++;
      imem_data = imem_addr ^ 8'hA5;
      imem_ack  = (reqCycles > ackDelay);
      if (imem_addr !== pc) addrErr++;
      if (imem_ack) begin
        lastFetch = imem_data;
        if (reqCycles != ackDelay + 1) reqLenErr++;
      end
    end else begin
      reqCycles = 0;
      imem_ack  = 1'b0;
    end
    if (commit === 1'b1) begin
      commitsSeen++;
      if (instr !== lastFetch) instrErr++;
    end
    tick();
  endtask

  task automatic clearStats();
    addrErr = 0; reqLenErr = 0; instrErr = 0; commitsSeen = 0;
  endtask

  initial begin
    int n;
    int fetchCnt;
    int bpReq;
    run = 0; step = 0; halt = 0; bp_en = 0; bp_addr = 8'h00; pc = 8'h00;
    imem_ack = 0; imem_data = 8'h00; ackDelay = 0; reqCycles = 0; lastFetch = 8'h00;
    clearStats();

    // Reset state
    Reset = 1'b1;
    #1 Reset = 1'b0;
    tick(); tick();
    check("rst_halted", halted, 1'b1);
    check("rst_req", imem_req, 1'b0);
    check("rst_commit", commit, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_retired", retired, 4'd0);
    check("rst_instr", instr, 8'h00);
    check("rst_state", state, 2'd0);
    Reset = 1'b1;
    tick();

    // Single step, zero-wait memory
    pc = 8'h03;
    step = 1'b1; tick(); step = 1'b0;
    check("step_k1_state", state, 2'd1);
    check("step_k1_req", imem_req, 1'b1);
    check("step_k1_addr", imem_addr, 8'h03);
    check("step_k1_commit", commit, 1'b0);
    imem_ack = 1'b1; imem_data = 8'h5A;
    tick();
    imem_ack = 1'b0;
    check("step_k2_instr", instr, 8'h5A);
    check("step_k2_commit", commit, 1'b1);
    check("step_k2_req", imem_req, 1'b0);
    tick();
    check("step_k3_state", state, 2'd0);
    check("step_k3_halted", halted, 1'b1);
    check("step_k3_commit", commit, 1'b0);
    check("step_k3_retired", retired, 4'd1);

    // Run with ack delayed 3 cycles: 10 instructions in 50 cycles, then halt
    clearStats();
    ackDelay = 3;
    run = 1'b1; cycle(); run = 1'b0;
    check("run_k1_req", imem_req, 1'b1);
    for (int i = 0; i < 50; i++) cycle();
    check("run_50cyc_commits", commitsSeen, 10);
    check("run_50cyc_retired", retired, 4'd11);
    halt = 1'b1; cycle(); halt = 1'b0;
    n = 0;
    while (halted !== 1'b1 && n < 30) begin cycle(); n++; end
    check("run_halt_reached", halted, 1'b1);
    check("run_total_commits", commitsSeen, 11);
    check("run_addr_stable", addrErr, 0);
    check("run_req_len", reqLenErr, 0);
    check("run_instr", instrErr, 0);
    check("run_final_pc", pc, 8'h0F);
    check("run_retired", retired, 4'd12);

    // Breakpoint at 8'h04 with PC starting at 0; retired wraps 15 -> 0
    clearStats();
    ackDelay = 0; pc = 8'h00; bp_en = 1'b1; bp_addr = 8'h04; bpReq = 0;
    run = 1'b1; cycle(); run = 1'b0;
    n = 0;
    while (halted !== 1'b1 && n < 40) begin
      if (imem_req === 1'b1 && imem_addr === 8'h04) bpReq++;
      cycle(); n++;
    end
    check("bp_halted", halted, 1'b1);
    check("bp_commits", commitsSeen, 4);
    check("bp_pc", pc, 8'h04);
    check("bp_no_req", bpReq, 0);
    check("bp_retired_wrap", retired, 4'd0);

    // Second run executes 8'h04; halt pulse during its EXEC stops after it
    clearStats();
    run = 1'b1; cycle(); run = 1'b0;
    check("bp2_req", imem_req, 1'b1);
    check("bp2_addr", imem_addr, 8'h04);
    cycle();
    check("bp2_commit", commit, 1'b1);
    check("bp2_instr", instr, 8'hA1);
    halt = 1'b1; cycle(); halt = 1'b0;
    check("bp2_halted", halted, 1'b1);
    check("bp2_commits", commitsSeen, 1);
    check("bp2_pc", pc, 8'h05);
    bp_en = 1'b0;

    // halt in the same cycle as imem_ack: instruction still commits
    clearStats();
    run = 1'b1; cycle(); run = 1'b0;
    halt = 1'b1; cycle(); halt = 1'b0;
    check("hack_commit", commit, 1'b1);
    check("hack_instr", instr, 8'hA0);
    cycle();
    check("hack_state", state, 2'd0);
    check("hack_retired", retired, 4'd2);

    // halt and run together while halted: stays halted
    halt = 1'b1; run = 1'b1; cycle(); halt = 1'b0; run = 1'b0;
    check("hrun_halted", halted, 1'b1);
    check("hrun_req", imem_req, 1'b0);
    cycle();
    check("hrun_state", state, 2'd0);

    // Watchdog: ack never arrives
    clearStats();
    ackDelay = 1000;
    step = 1'b1; cycle(); step = 1'b0;
    fetchCnt = 0; n = 0;
    while (halted !== 1'b1 && n < 40) begin
      if (state === 2'd1) fetchCnt++;
      cycle(); n++;
    end
    check("wd_fetch_cycles", fetchCnt, 15);
    check("wd_fault", fault, 1'b1);
    check("wd_no_commit", commitsSeen, 0);
    check("wd_instr_kept", instr, 8'hA0);
    ackDelay = 0;
    step = 1'b1; cycle(); step = 1'b0;
    check("wd_fault_cleared", fault, 1'b0);
    check("wd_refetch_state", state, 2'd1);
    cycle(); cycle();
    check("wd_step_instr", instr, 8'hA3);
    check("wd_step_retired", retired, 4'd3);
    check("wd_step_halted", halted, 1'b1);

    // Asynchronous reset asserted mid-FETCH
    ackDelay = 1000;
    step = 1'b1; cycle(); step = 1'b0;
    check("mid_pre_req", imem_req, 1'b1);
    Reset = 1'b0;
    #1;
    check("mid_req", imem_req, 1'b0);
    check("mid_halted", halted, 1'b1);
    check("mid_retired", retired, 4'd0);
    check("mid_instr", instr, 8'h00);
    check("mid_state", state, 2'd0);
    tick();
    Reset = 1'b1;
    tick();
    check("post_rst_commit", commit, 1'b0);
    check("post_rst_halted", halted, 1'b1);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
